prog_counter: RTL and testbench
===============================

# prog_counter

Parametrised, programmable successor to the free-running event counter. Counts up or down between 0 and a runtime limit, advances on a programmable prescaled tick, and runs in wrap (periodic) or one-shot mode. Emits a single-cycle terminal-count pulse. Used as the general timebase and interval timer for downstream control logic.

## Interface
- WIDTH, 16, count and limit width
- PRESCALE_W, 8, prescaler divisor width
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- en  in  1  1 = prescaler and counter may advance; 0 = pause (everything holds)
- start  in  1  launch run; loads start value, clears prescaler
- load  in  1  synchronous load of load_val into count
- load_val  in  WIDTH  value written by load
- dir  in  1  0 = up, 1 = down
- mode  in  1  0 = wrap, 1 = one-shot
- limit  in  WIDTH  terminal value (up) or start value (down)
- prescale  in  PRESCALE_W  tick every prescale+1 enabled cycles
- count  out  WIDTH  current count
- tc  out  1  terminal-count pulse, one cycle
- busy  out  1  state == RUN
- done  out  1  state == DONE (one-shot finished)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; count=0, tc=0, busy=0, done=0, prescaler=0.
- Start value: 0 when dir=0, limit when dir=1.
- Priority per cycle: load > start > tick.
- load (any state): count ← load_val, prescaler ← 0, state unchanged, start ignored that cycle, no tc.
- start (IDLE/DONE/RUN): state → RUN, count ← start value, prescaler ← 0.
- Prescaler: in RUN with en=1, tick when pre_cnt == prescale; pre_cnt then ← 0, else pre_cnt+1. prescale=0 → tick every enabled cycle. en=0 or state≠RUN: pre_cnt holds.
- On tick, terminal condition: up: count >= limit (covers limit lowered mid-run); down: count == 0.
- Tick, not terminal: count ± 1 (modulo 2^WIDTH arithmetic, never reached for valid limit).
- Tick, terminal: tc=1 next cycle; wrap → count ← start value, stay RUN; one-shot → count holds, state → DONE.
- dir, limit, mode changes mid-run take effect at the next tick using current values.
- In IDLE/DONE count holds; only load/start change it.

## Timing
- All outputs registered; tc high exactly one cycle, coincident with the reloaded/held count.
- start sampled at edge N: busy=1 after N; with en held, first count change at edge N+1+prescale; tick period prescale+1 cycles.
- Wrap period: (limit+1)·(prescale+1) cycles, up or down.
- One-shot: done and tc assert together at edge N+(limit+1)·(prescale+1); done holds until start or reset.
- rst asserted mid-run: immediate (asynchronous) return to reset values; no tc generated.

## Structure
- Package counter_pkg: state enum (IDLE, RUN, DONE), dir and mode encodings as named constants.
- Sub-module prescaler_tick (PRESCALE_W parameter; inputs clk, rst, en, clear, prescale; output tick) instantiated once.
- Top holds FSM, count register, terminal compare and tc register.

## Test plan
- Wrap up, limit=3, prescale=0, en=1, start → count 1,2,3,0,1…; tc once every 4 cycles, coincident with count=0.
- One-shot down, limit=5, prescale=2, start at edge N → count decrements every 3 cycles; tc and done at edge N+18, count stays 0, busy=0.
- en low for 7 cycles mid-run → count and prescaler frozen; resumes with remaining prescaler phase.
- load=1 and start=1 same cycle, load_val=0x1234, state IDLE → count=0x1234, state IDLE, no tc.
- Up run at count=10, limit changed to 4 → next tick: tc pulse, count 0 (wrap) or DONE (one-shot).
- rst pulsed while RUN at count=0x00FF → count=0, busy=0, done=0, tc=0 immediately; no activity until start.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and encodings for the programmable counter.
package counter_pkg;

    // FSM states of the counter controller.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Count direction encodings.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Run mode encodings.
    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/prog_counter_if.sv
// Control/status bundle for prog_counter: the master drives the controls,
// the slave (the counter) returns count and status.
interface prog_counter_if #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
);
    logic                  en;
    logic                  start;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic                  dir;
    logic                  mode;
    logic [WIDTH-1:0]      limit;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  busy;
    logic                  done;

    modport master (
        output en, start, load, load_val, dir, mode, limit, prescale,
        input  count, tc, busy, done
    );

    modport slave (
        input  en, start, load, load_val, dir, mode, limit, prescale,
        output count, tc, busy, done
    );
endinterface

// File: rtl/prog_counter_prescaler_tick.sv
// Prescaler: raises tick on every (prescale+1)-th enabled cycle.
// The phase counter holds while en is low so a paused run resumes
// with its remaining phase intact.
module prescaler_tick #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] pre_cnt;

    // A clear in the same cycle suppresses the tick: load/start win over counting.
    assign tick = en && !clear && (pre_cnt == prescale);

    // Phase counter: clear, advance while enabled, restart on reaching prescale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (clear) begin
            pre_cnt <= '0;
        end else if (en) begin
            if (pre_cnt == prescale) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaled tick, wrap or one-shot mode
// and a single-cycle terminal-count pulse.
//
//   state | meaning
//   IDLE  | after reset, count holds, waiting for start
//   RUN   | counting on each prescaler tick
//   DONE  | one-shot reached terminal value, count holds until start
module prog_counter
    import counter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    prog_counter_if.slave   bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] start_val;
    logic             terminal;
    logic             tick;

    prescaler_tick #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.en && (state_q == RUN)),
        .clear    (bus.load || bus.start),
        .prescale (bus.prescale),
        .tick     (tick)
    );

    assign start_val = (bus.dir == DIR_DOWN) ? bus.limit : '0;

    // ">=" rather than "==" so a limit lowered below count mid-run still terminates.
    assign terminal = (bus.dir == DIR_DOWN) ? (count_q == '0) : (count_q >= bus.limit);

    // Next state, count and tc: load beats start, start beats tick.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            count_d = bus.load_val;
        end else if (bus.start) begin
            state_d = RUN;
            count_d = start_val;
        end else if (tick) begin
            if (terminal) begin
                tc_d = 1'b1;
                if (bus.mode == MODE_ONESHOT) begin
                    state_d = DONE;
                end else begin
                    count_d = start_val;
                end
            end else if (bus.dir == DIR_DOWN) begin
                count_d = count_q - 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // State, count and terminal pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: wrap, one-shot, pause, load priority,
// limit change mid-run and asynchronous reset.
module tb_prog_counter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    prog_counter_if #(.WIDTH(16), .PRESCALE_W(8)) bus ();

    prog_counter #(.WIDTH(16), .PRESCALE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b0; bus.start = 1'b0; bus.load = 1'b0; bus.load_val = '0;
        bus.dir = 1'b0; bus.mode = 1'b0; bus.limit = '0; bus.prescale = '0;
        step(2);
        checks++;
        if (bus.count !== 16'd0 || bus.tc !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset: count=%0h tc=%b busy=%b done=%b, want 0 0 0 0",
                     bus.count, bus.tc, bus.busy, bus.done);
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_wrap_up();
        bus.en = 1'b1; bus.dir = 1'b0; bus.mode = 1'b0; bus.limit = 16'd3; bus.prescale = 8'd0;
        pulse_start();
        checks++;
        if (bus.count !== 16'd0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL wrap_start: count=%0d busy=%b, want 0 1", bus.count, bus.busy);
        end
        for (int k = 1; k <= 9; k++) begin
            step(1);
            checks++;
            if (bus.count !== 16'(k % 4) || bus.tc !== (k % 4 == 0)) begin
                failures++;
                $display("FAIL wrap_up k=%0d: count=%0d tc=%b, want %0d %b",
                         k, bus.count, bus.tc, k % 4, (k % 4 == 0));
            end
        end
    endtask

    task automatic test_oneshot_down();
        logic [15:0] exp_cnt;
        bus.en = 1'b1; bus.dir = 1'b1; bus.mode = 1'b1; bus.limit = 16'd5; bus.prescale = 8'd2;
        pulse_start();
        checks++;
        if (bus.count !== 16'd5 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_start: count=%0d busy=%b, want 5 1", bus.count, bus.busy);
        end
        for (int k = 1; k <= 21; k++) begin
            step(1);
            exp_cnt = (k >= 15) ? 16'd0 : 16'(5 - k / 3);
            checks++;
            if (bus.count !== exp_cnt || bus.tc !== (k == 18) ||
                bus.done !== (k >= 18) || bus.busy !== (k < 18)) begin
                failures++;
                $display("FAIL oneshot_down k=%0d: count=%0d tc=%b done=%b busy=%b, want %0d %b %b %b",
                         k, bus.count, bus.tc, bus.done, bus.busy,
                         exp_cnt, (k == 18), (k >= 18), (k < 18));
            end
        end
    endtask

    task automatic test_pause();
        bus.en = 1'b1; bus.dir = 1'b0; bus.mode = 1'b0; bus.limit = 16'd100; bus.prescale = 8'd3;
        pulse_start();
        step(2);
        bus.en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step(1);
            checks++;
            if (bus.count !== 16'd0 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL pause_hold k=%0d: count=%0d busy=%b, want 0 1", k, bus.count, bus.busy);
            end
        end
        bus.en = 1'b1;
        step(1);
        checks++;
        if (bus.count !== 16'd0) begin
            failures++;
            $display("FAIL pause_resume1: count=%0d, want 0", bus.count);
        end
        step(1);
        checks++;
        if (bus.count !== 16'd1) begin
            failures++;
            $display("FAIL pause_resume2: count=%0d, want 1", bus.count);
        end
        step(3);
        checks++;
        if (bus.count !== 16'd1) begin
            failures++;
            $display("FAIL pause_period_a: count=%0d, want 1", bus.count);
        end
        step(1);
        checks++;
        if (bus.count !== 16'd2) begin
            failures++;
            $display("FAIL pause_period_b: count=%0d, want 2", bus.count);
        end
    endtask

    task automatic test_load_start();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step(1);
        bus.en = 1'b1; bus.prescale = 8'd0; bus.dir = 1'b0; bus.limit = 16'hFFFF;
        bus.load = 1'b1; bus.start = 1'b1; bus.load_val = 16'h1234;
        step(1);
        bus.load = 1'b0; bus.start = 1'b0;
        checks++;
        if (bus.count !== 16'h1234 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tc !== 1'b0) begin
            failures++;
            $display("FAIL load_start: count=%0h busy=%b done=%b tc=%b, want 1234 0 0 0",
                     bus.count, bus.busy, bus.done, bus.tc);
        end
        step(3);
        checks++;
        if (bus.count !== 16'h1234 || bus.tc !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: count=%0h tc=%b, want 1234 0", bus.count, bus.tc);
        end
    endtask

    task automatic test_limit_lower();
        bus.en = 1'b1; bus.dir = 1'b0; bus.mode = 1'b0; bus.limit = 16'd20; bus.prescale = 8'd0;
        pulse_start();
        step(10);
        bus.limit = 16'd4;
        step(1);
        checks++;
        if (bus.count !== 16'd0 || bus.tc !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL limit_wrap: count=%0d tc=%b busy=%b, want 0 1 1", bus.count, bus.tc, bus.busy);
        end
        step(1);
        checks++;
        if (bus.count !== 16'd1 || bus.tc !== 1'b0) begin
            failures++;
            $display("FAIL limit_wrap_next: count=%0d tc=%b, want 1 0", bus.count, bus.tc);
        end
        // restart while already running
        pulse_start();
        checks++;
        if (bus.count !== 16'd0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL restart: count=%0d busy=%b, want 0 1", bus.count, bus.busy);
        end
        bus.mode = 1'b1; bus.limit = 16'd20;
        pulse_start();
        step(10);
        bus.limit = 16'd4;
        step(1);
        checks++;
        if (bus.count !== 16'd10 || bus.tc !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL limit_oneshot: count=%0d tc=%b done=%b busy=%b, want 10 1 1 0",
                     bus.count, bus.tc, bus.done, bus.busy);
        end
        step(2);
        checks++;
        if (bus.count !== 16'd10 || bus.tc !== 1'b0 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL done_hold: count=%0d tc=%b done=%b, want 10 0 1", bus.count, bus.tc, bus.done);
        end
    endtask

    task automatic test_reset_midrun();
        bus.en = 1'b1; bus.dir = 1'b0; bus.mode = 1'b0; bus.limit = 16'h0200; bus.prescale = 8'd0;
        pulse_start();
        bus.load = 1'b1; bus.load_val = 16'h00FF;
        step(1);
        bus.load = 1'b0;
        checks++;
        if (bus.count !== 16'h00FF || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL load_run: count=%0h busy=%b, want ff 1", bus.count, bus.busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.count !== 16'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tc !== 1'b0) begin
            failures++;
            $display("FAIL async_rst: count=%0h busy=%b done=%b tc=%b, want 0 0 0 0",
                     bus.count, bus.busy, bus.done, bus.tc);
        end
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            checks++;
            if (bus.count !== 16'd0 || bus.busy !== 1'b0 || bus.tc !== 1'b0) begin
                failures++;
                $display("FAIL post_rst k=%0d: count=%0h busy=%b tc=%b, want 0 0 0",
                         k, bus.count, bus.busy, bus.tc);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_wrap_up();
        test_oneshot_down();
        test_pause();
        test_load_start();
        test_limit_lower();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
